// File: rtl/xmit_frame_gen_pkg.sv
// Shared types and helpers for the hi/lo-priority frame generator.
package xmit_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_GAP  = 2'd3
    } gen_state_e;

    // Builds the {len,len} control word; the caller truncates to 2*len_w bits.
    function automatic logic [63:0] pack_ctrl(input logic [31:0] len, input int unsigned len_w);
        return (64'(len) << len_w) | 64'(len);
    endfunction

endpackage

// File: rtl/xmit_frame_gen_if.sv
// Frame output bus from the generator towards the xmit receive side.
interface xmit_frame_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 12
);
    logic [DATA_W-1:0]  f_data_in;
    logic [2*LEN_W-1:0] f_ctrl_in;
    logic               f_rec_data_valid;
    logic               f_rec_frame_valid;
    logic               f_hi_priority;

    modport master (
        output f_data_in, f_ctrl_in, f_rec_data_valid, f_rec_frame_valid, f_hi_priority
    );

    modport slave (
        input  f_data_in, f_ctrl_in, f_rec_data_valid, f_rec_frame_valid, f_hi_priority
    );
endinterface

// File: rtl/xmit_frame_gen_seq_ctr.sv
// Per-class payload sequence counter: reset/load to SEED, increment wraps mod 2^DATA_W.
module xmit_seq_ctr #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEED   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              inc_i,
    output logic [DATA_W-1:0] val_o
);
    logic [DATA_W-1:0] val_q;

    // Sequence value register; load has priority over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= DATA_W'(SEED);
        end else if (load_i) begin
            val_q <= DATA_W'(SEED);
        end else if (inc_i) begin
            val_q <= val_q + DATA_W'(1);
        end
    end

    assign val_o = val_q;
endmodule

// File: rtl/xmit_frame_gen.sv
// Hi/lo-priority frame generator: rounds of HI_PER_LO hi frames then one lo frame.
module xmit_frame_gen
    import xmit_gen_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned HI_PER_LO  = 10,
    parameter int unsigned NUM_ROUNDS = 256,
    parameter int unsigned GAP        = 0,
    parameter int unsigned HI_SEED    = 240,
    parameter int unsigned LO_SEED    = 0
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [LEN_W-1:0] hi_len,
    input  logic [LEN_W-1:0] lo_len,
    xmit_frame_gen_if.master fo,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CTRL_W = 2 * LEN_W;
    localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int unsigned HI_W   = (HI_PER_LO > 0) ? $clog2(HI_PER_LO + 1) : 1;
    localparam int unsigned RND_W  = (NUM_ROUNDS > 0) ? $clog2(NUM_ROUNDS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [HI_W-1:0]  HI_LIMIT  = HI_W'(HI_PER_LO);
    localparam logic [RND_W-1:0] RND_LIMIT = RND_W'(NUM_ROUNDS);

    gen_state_e        state_q, state_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic [LEN_W-1:0]  hi_len_q, hi_len_d;
    logic [LEN_W-1:0]  lo_len_q, lo_len_d;
    logic              done_q, done_d;

    logic              hi_inc, lo_inc, boundary;
    logic [LEN_W-1:0]  cur_len, len_m1;
    logic              last_beat;
    logic [DATA_W-1:0] hi_seq, lo_seq;

    xmit_seq_ctr #(.DATA_W(DATA_W), .SEED(HI_SEED)) u_hi_seq (
        .clk_i (clk_sys),
        .rst_ni(reset_n),
        .load_i(1'b0),
        .inc_i (hi_inc),
        .val_o (hi_seq)
    );

    xmit_seq_ctr #(.DATA_W(DATA_W), .SEED(LO_SEED)) u_lo_seq (
        .clk_i (clk_sys),
        .rst_ni(reset_n),
        .load_i(1'b0),
        .inc_i (lo_inc),
        .val_o (lo_seq)
    );

    // A zero length still produces a single beat.
    assign cur_len   = (state_q == ST_LO) ? lo_len_q : hi_len_q;
    assign len_m1    = (cur_len == '0) ? '0 : cur_len - LEN_W'(1);
    assign last_beat = (beat_q == len_m1);

    // State and counter registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            gap_q    <= '0;
            hi_cnt_q <= '0;
            round_q  <= '0;
            hi_len_q <= '0;
            lo_len_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            hi_cnt_q <= hi_cnt_d;
            round_q  <= round_d;
            hi_len_q <= hi_len_d;
            lo_len_q <= lo_len_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. Every frame start (from start, a frame end or a gap end)
    // funnels through "boundary", where finish, pause-hold and class choice are decided;
    // a pause hold reuses the GAP state with an expired gap count.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        hi_cnt_d = hi_cnt_q;
        round_d  = round_q;
        hi_len_d = hi_len_q;
        lo_len_d = lo_len_q;
        done_d   = 1'b0;
        hi_inc   = 1'b0;
        lo_inc   = 1'b0;
        boundary = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    hi_len_d = hi_len;
                    lo_len_d = lo_len;
                    hi_cnt_d = '0;
                    round_d  = '0;
                    boundary = 1'b1;
                end
            end
            ST_HI, ST_LO: begin
                if (last_beat) begin
                    beat_d = '0;
                    if (state_q == ST_HI) begin
                        hi_cnt_d = hi_cnt_q + HI_W'(1);
                        hi_inc   = 1'b1;
                    end else begin
                        hi_cnt_d = '0;
                        round_d  = round_q + RND_W'(1);
                        lo_inc   = 1'b1;
                    end
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LAST;
                    end else begin
                        boundary = 1'b1;
                    end
                end else begin
                    beat_d = beat_q + LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    boundary = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (boundary) begin
            beat_d = '0;
            gap_d  = '0;
            if ((NUM_ROUNDS != 0) && (round_d == RND_LIMIT)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else if (pause) begin
                state_d = ST_GAP;
            end else if (hi_cnt_d < HI_LIMIT) begin
                state_d = ST_HI;
            end else begin
                state_d = ST_LO;
            end
        end

        if (abort) begin
            state_d  = ST_IDLE;
            beat_d   = '0;
            gap_d    = '0;
            done_d   = 1'b0;
            hi_inc   = 1'b0;
            lo_inc   = 1'b0;
            hi_len_d = hi_len_q;
            lo_len_d = lo_len_q;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        fo.f_data_in         = '0;
        fo.f_ctrl_in         = '0;
        fo.f_rec_data_valid  = 1'b0;
        fo.f_rec_frame_valid = 1'b0;
        fo.f_hi_priority     = 1'b0;
        if ((state_q == ST_HI) || (state_q == ST_LO)) begin
            fo.f_rec_data_valid = 1'b1;
            fo.f_hi_priority    = (state_q == ST_HI);
            fo.f_data_in        = (state_q == ST_HI) ? hi_seq : lo_seq;
            if (beat_q == '0) begin
                fo.f_rec_frame_valid = 1'b1;
                fo.f_ctrl_in         = CTRL_W'(pack_ctrl(32'(cur_len), LEN_W));
            end
        end
        busy = (state_q != ST_IDLE) || done_q;
        done = done_q;
    end
endmodule

// File: tb/tb_xmit_frame_gen.sv
// Directed bench for xmit_frame_gen: four instances with different parameter sets.
module tb_xmit_frame_gen;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [3:0]  start_v;
    logic        abort, pause;
    logic [11:0] hi_len, lo_len;
    logic [3:0]  busy_v, done_v;

    always #5 clk_sys = ~clk_sys;

    xmit_frame_gen_if #(.DATA_W(8), .LEN_W(12)) if0 ();
    xmit_frame_gen_if #(.DATA_W(8), .LEN_W(12)) if1 ();
    xmit_frame_gen_if #(.DATA_W(8), .LEN_W(12)) if2 ();
    xmit_frame_gen_if #(.DATA_W(8), .LEN_W(12)) if3 ();

    xmit_frame_gen #(.NUM_ROUNDS(1)) u0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_v[0]), .abort(abort), .pause(pause),
        .hi_len(hi_len), .lo_len(lo_len), .fo(if0), .busy(busy_v[0]), .done(done_v[0]));
    xmit_frame_gen #(.HI_SEED(250), .NUM_ROUNDS(2)) u1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_v[1]), .abort(abort), .pause(pause),
        .hi_len(hi_len), .lo_len(lo_len), .fo(if1), .busy(busy_v[1]), .done(done_v[1]));
    xmit_frame_gen #(.GAP(3), .HI_PER_LO(2), .NUM_ROUNDS(1)) u2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_v[2]), .abort(abort), .pause(pause),
        .hi_len(hi_len), .lo_len(lo_len), .fo(if2), .busy(busy_v[2]), .done(done_v[2]));
    xmit_frame_gen #(.HI_PER_LO(0), .NUM_ROUNDS(2)) u3 (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_v[3]), .abort(abort), .pause(pause),
        .hi_len(hi_len), .lo_len(lo_len), .fo(if3), .busy(busy_v[3]), .done(done_v[3]));

    logic [1:0]  sel;
    logic        obs_dv, obs_fv, obs_hi, obs_busy, obs_done;
    logic [7:0]  obs_data;
    logic [23:0] obs_ctrl;

    always_comb begin
        case (sel)
            2'd1: begin
                obs_dv = if1.f_rec_data_valid; obs_fv = if1.f_rec_frame_valid;
                obs_hi = if1.f_hi_priority; obs_data = if1.f_data_in; obs_ctrl = if1.f_ctrl_in;
            end
            2'd2: begin
                obs_dv = if2.f_rec_data_valid; obs_fv = if2.f_rec_frame_valid;
                obs_hi = if2.f_hi_priority; obs_data = if2.f_data_in; obs_ctrl = if2.f_ctrl_in;
            end
            2'd3: begin
                obs_dv = if3.f_rec_data_valid; obs_fv = if3.f_rec_frame_valid;
                obs_hi = if3.f_hi_priority; obs_data = if3.f_data_in; obs_ctrl = if3.f_ctrl_in;
            end
            default: begin
                obs_dv = if0.f_rec_data_valid; obs_fv = if0.f_rec_frame_valid;
                obs_hi = if0.f_hi_priority; obs_data = if0.f_data_in; obs_ctrl = if0.f_ctrl_in;
            end
        endcase
        obs_busy = busy_v[sel];
        obs_done = done_v[sel];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Recorded frames of the most recent collect() call.
    logic [7:0]  fd [32];
    logic [23:0] fc [32];
    logic        fh [32];
    int          fb [32];
    int          fi [32];
    int          nf, done_cyc, adj_cnt, var_errs, beat_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_start();
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
    endtask

    // Samples the selected DUT from cycle 1 after start until done or max_cyc.
    // pause is high for cycles [pon,poff); abort/start pulse at the given cycles.
    task automatic collect(input int max_cyc, input int pon, input int poff,
                           input int abort_at, input int restart_at);
        int   idle_run;
        logic prev_dv;
        idle_run = 0; prev_dv = 1'b0;
        nf = 0; done_cyc = 0; adj_cnt = 0; var_errs = 0; beat_sum = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (obs_fv) begin
                if (!obs_dv) var_errs++;
                if (prev_dv) adj_cnt++;
                if (nf < 32) begin
                    fd[nf] = obs_data; fc[nf] = obs_ctrl; fh[nf] = obs_hi;
                    fb[nf] = 0; fi[nf] = idle_run;
                    nf++;
                end else begin
                    var_errs++;
                end
            end
            if (obs_dv) begin
                beat_sum++;
                idle_run = 0;
                if (nf == 0) var_errs++;
                else begin
                    fb[nf-1] = fb[nf-1] + 1;
                    if (obs_data !== fd[nf-1] || obs_hi !== fh[nf-1]) var_errs++;
                end
            end else begin
                idle_run++;
            end
            prev_dv = obs_dv;
            if (obs_done) begin
                done_cyc = cyc;
                break;
            end
            pause        = (cyc >= pon && cyc < poff);
            abort        = (cyc == abort_at);
            start_v[sel] = (cyc == restart_at);
            tick();
        end
        pause = 1'b0; abort = 1'b0; start_v = '0;
    endtask

    initial begin
        reset_n = 1'b0; start_v = '0; abort = 1'b0; pause = 1'b0;
        hi_len = '0; lo_len = '0; sel = 2'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_dv", obs_dv, 0);
        chk("rst_fv", obs_fv, 0);
        chk("rst_data", obs_data, 0);
        chk("rst_ctrl", obs_ctrl, 0);
        chk("rst_hi", obs_hi, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_done", obs_done, 0);
        reset_n = 1'b1;
        tick();

        // 1: default round, hi 512 / lo 64
        hi_len = 12'd512; lo_len = 12'd64;
        pulse_start();
        hi_len = 12'd7; lo_len = 12'd9;
        collect(6000, 0, 0, 0, 0);
        chk("t1_nframes", nf, 11);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_hdata%0d", i), fd[i], 240 + i);
            chk($sformatf("t1_hctrl%0d", i), fc[i], 24'h200200);
            chk($sformatf("t1_hcls%0d", i), fh[i], 1);
            chk($sformatf("t1_hbeats%0d", i), fb[i], 512);
        end
        chk("t1_ldata", fd[10], 0);
        chk("t1_lctrl", fc[10], 24'h040040);
        chk("t1_lcls", fh[10], 0);
        chk("t1_lbeats", fb[10], 64);
        chk("t1_var", var_errs, 0);
        chk("t1_adj_strobes", adj_cnt, 10);
        chk("t1_done_cyc", done_cyc, 5185);
        chk("t1_busy_at_done", obs_busy, 1);
        tick();
        chk("t1_busy_after", obs_busy, 0);
        chk("t1_done_after", obs_done, 0);

        // 4: pause raised mid-frame 0 (hi seq now 250, lo seq 1)
        hi_len = 12'd3; lo_len = 12'd2;
        pulse_start();
        collect(100, 2, 7, 0, 0);
        chk("t4_nframes", nf, 11);
        chk("t4_f0_beats", fb[0], 3);
        chk("t4_f1_idle", fi[1], 4);
        chk("t4_f2_idle", fi[2], 0);
        chk("t4_beats", beat_sum, 32);
        chk("t4_hdata5", fd[5], 255);
        chk("t4_hdata6", fd[6], 0);
        chk("t4_hdata9", fd[9], 3);
        chk("t4_ldata", fd[10], 1);
        chk("t4_var", var_errs, 0);
        chk("t4_done_cyc", done_cyc, 37);
        tick();

        // 5: abort mid-frame (hi seq now 4, lo seq 2)
        hi_len = 12'd4; lo_len = 12'd4;
        pulse_start();
        collect(8, 0, 0, 2, 0);
        chk("t5_nframes", nf, 1);
        chk("t5_beats", fb[0], 2);
        chk("t5_data", fd[0], 4);
        chk("t5_no_done", done_cyc, 0);
        chk("t5_busy", obs_busy, 0);
        chk("t5_dv", obs_dv, 0);
        // restart continues the hi sequence; aborted frame did not advance it
        pulse_start();
        collect(6, 0, 0, 1, 0);
        chk("t5r_nframes", nf, 1);
        chk("t5r_data", fd[0], 4);
        chk("t5r_beats", fb[0], 1);
        chk("t5r_ctrl", fc[0], 24'h004004);

        // abort beats start
        start_v[0] = 1'b1; abort = 1'b1;
        tick();
        start_v[0] = 1'b0; abort = 1'b0;
        chk("abst_busy", obs_busy, 0);
        tick();
        chk("abst_dv", obs_dv, 0);

        // asynchronous reset mid-frame
        pulse_start();
        tick();
        chk("arst_pre_dv", obs_dv, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_dv", obs_dv, 0);
        chk("arst_fv", obs_fv, 0);
        chk("arst_data", obs_data, 0);
        chk("arst_busy", obs_busy, 0);
        #2 reset_n = 1'b1;
        tick();

        // 6: zero lengths, second start while busy, start during done
        hi_len = 12'd0; lo_len = 12'd0;
        pulse_start();
        collect(40, 0, 0, 0, 3);
        chk("t6_nframes", nf, 11);
        chk("t6_f0_data", fd[0], 240);
        chk("t6_f0_ctrl", fc[0], 0);
        chk("t6_f0_beats", fb[0], 1);
        chk("t6_f9_data", fd[9], 249);
        chk("t6_l_data", fd[10], 0);
        chk("t6_l_beats", fb[10], 1);
        chk("t6_beats", beat_sum, 11);
        chk("t6_done_cyc", done_cyc, 12);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("t6_start_at_done_busy", obs_busy, 0);
        chk("t6_start_at_done_dv", obs_dv, 0);

        // 2: HI_SEED=250, two rounds
        sel = 2'd1;
        hi_len = 12'd2; lo_len = 12'd1;
        pulse_start();
        collect(100, 0, 0, 0, 0);
        chk("t2_nframes", nf, 22);
        chk("t2_f5_data", fd[5], 255);
        chk("t2_f6_data", fd[6], 0);
        chk("t2_f9_data", fd[9], 3);
        chk("t2_lo0_data", fd[10], 0);
        chk("t2_lo0_cls", fh[10], 0);
        chk("t2_f11_data", fd[11], 4);
        chk("t2_f11_cls", fh[11], 1);
        chk("t2_lo1_data", fd[21], 1);
        chk("t2_lo1_ctrl", fc[21], 24'h001001);
        chk("t2_var", var_errs, 0);
        chk("t2_done_cyc", done_cyc, 43);
        tick();

        // 3: GAP=3, two hi per lo, len 4
        sel = 2'd2;
        hi_len = 12'd4; lo_len = 12'd4;
        pulse_start();
        collect(100, 0, 0, 0, 0);
        chk("t3_nframes", nf, 3);
        chk("t3_adjacent", adj_cnt, 0);
        chk("t3_f1_idle", fi[1], 3);
        chk("t3_f2_idle", fi[2], 3);
        chk("t3_f0_beats", fb[0], 4);
        chk("t3_f2_beats", fb[2], 4);
        chk("t3_f1_data", fd[1], 241);
        chk("t3_f2_data", fd[2], 0);
        chk("t3_f2_cls", fh[2], 0);
        chk("t3_done_cyc", done_cyc, 22);
        tick();

        // HI_PER_LO=0: lo-only rounds
        sel = 2'd3;
        hi_len = 12'd5; lo_len = 12'd2;
        pulse_start();
        collect(50, 0, 0, 0, 0);
        chk("lo_only_nframes", nf, 2);
        chk("lo_only_cls0", fh[0], 0);
        chk("lo_only_cls1", fh[1], 0);
        chk("lo_only_data0", fd[0], 0);
        chk("lo_only_data1", fd[1], 1);
        chk("lo_only_beats", beat_sum, 4);
        chk("lo_only_done_cyc", done_cyc, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
